// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: synchronizer chain plus a
// four-state qualify FSM per channel, with registered level and edge pulses.
module btn_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    TO_HIGH,
    HIGH,
    TO_LOW
  } state_t;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_d, fall_d;
    logic                   btn_q, rise_q, fall_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[g]};
      end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
        LOW: begin
          if (sync) begin
            state_d = TO_HIGH;
            cnt_d   = '0;
          end
        end
        TO_HIGH: begin
          if (!sync) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (!sync) begin
            state_d = TO_LOW;
            cnt_d   = '0;
          end
        end
        TO_LOW: begin
          if (sync) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = LOW;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = LOW;
          cnt_d   = '0;
        end
      endcase
    end

    // Level and pulses are separate flops so outputs never see decode logic.
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        state_q <= LOW;
        cnt_q   <= '0;
        btn_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        if (rise_d) begin
          btn_q <= 1'b1;
        end else if (fall_d) begin
          btn_q <= 1'b0;
        end
      end
    end

    assign btn_o[g]  = btn_q;
    assign rise_o[g] = rise_q;
    assign fall_o[g] = fall_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// accepted changes appear at edge 6 counted from the first edge after a change.
module tb_btn_debounce;

  logic       clk_i;
  logic       arstn_i;
  logic [3:0] btn_i;
  logic [3:0] btn_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;

  int n_chk;
  int n_fail;

  btn_debounce #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .btn_i  (btn_i),
    .btn_o  (btn_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    arstn_i = 1'b0;
    btn_i   = 4'b0000;
    #1;
    chk("rst_btn", btn_o, 4'h0);
    chk("rst_rise", rise_o, 4'h0);
    chk("rst_fall", fall_o, 4'h0);
    tick();
    tick();
    @(negedge clk_i);
    arstn_i = 1'b1;
    tick();
    tick();
    chk("idle_btn", btn_o, 4'h0);

    // clean press on channel 0
    btn_i[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("press_btn%0d", k), btn_o[0], (k >= 6));
      chk($sformatf("press_rise%0d", k), rise_o[0], (k == 6));
      chk($sformatf("press_fall%0d", k), fall_o[0], 0);
    end

    // clean release on channel 0
    btn_i[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rel_btn%0d", k), btn_o[0], (k < 6));
      chk($sformatf("rel_fall%0d", k), fall_o[0], (k == 6));
      chk($sformatf("rel_rise%0d", k), rise_o[0], 0);
    end

    // bounce on channel 1: high 3, low 1, then held high
    btn_i[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("bnc_btn%0d", k), btn_o[1], (k >= 10));
      chk($sformatf("bnc_rise%0d", k), rise_o[1], (k == 10));
      chk($sformatf("bnc_others%0d", k), {btn_o[0], btn_o[3:2]}, 0);
      if (k == 2) btn_i[1] = 1'b0;
      if (k == 3) btn_i[1] = 1'b1;
    end

    btn_i[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("bnc_fall%0d", k), fall_o[1], (k == 6));
    end

    // all channels at once
    btn_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("all_rise%0d", k), rise_o, (k == 6) ? 4'hF : 4'h0);
      chk($sformatf("all_btn%0d", k), btn_o, (k >= 6) ? 4'hF : 4'h0);
      chk($sformatf("all_fall%0d", k), fall_o, 4'h0);
    end
    btn_i = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("all_fallp%0d", k), fall_o, (k == 6) ? 4'hF : 4'h0);
      chk($sformatf("all_btnf%0d", k), btn_o, (k >= 6) ? 4'h0 : 4'hF);
    end

    // channel 3 settled high, then a channel 0 press interrupted by reset
    btn_i[3] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk("ch3_high", btn_o, 4'h8);
    btn_i[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mid_rise%0d", k), rise_o, 4'h0);
    end
    arstn_i = 1'b0;
    #1;
    chk("mid_rst_btn", btn_o, 4'h0);
    chk("mid_rst_rise", rise_o, 4'h0);
    chk("mid_rst_fall", fall_o, 4'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("held_rise%0d", k), rise_o, 4'h0);
      chk($sformatf("held_btn%0d", k), btn_o, 4'h0);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("post_rise%0d", k), rise_o, (k == 6) ? 4'h9 : 4'h0);
      chk($sformatf("post_btn%0d", k), btn_o, (k >= 6) ? 4'h9 : 4'h0);
      chk($sformatf("post_fall%0d", k), fall_o, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, number of independent button channels.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops per channel, legal range 2..4.
REQ-003 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a level change, legal range >= 2.
REQ-004 SHALL provide port clk_i, input, 1 bit, system clock (PLL output domain).
REQ-005 SHALL provide port arstn_i, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL provide port btn_i, input, WIDTH bits, raw asynchronous push-button levels (BTNL/BTNU/BTNR/BTND order on the board).
REQ-007 SHALL provide port btn_o, output, WIDTH bits, debounced registered level per channel, suitable for direct connection to the SoC irq button inputs.
REQ-008 SHALL provide port rise_o, output, WIDTH bits, one-cycle pulse per accepted 0->1 change.
REQ-009 SHALL provide port fall_o, output, WIDTH bits, one-cycle pulse per accepted 1->0 change.

Function
REQ-010 Each channel SHALL pass btn_i through a SYNC_STAGES-deep flop chain; the last stage is the synchronized level, sync.
REQ-011 Each channel SHALL run an independent FSM with states LOW, TO_HIGH, HIGH and TO_LOW, plus a counter of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-012 In LOW with sync=1, the FSM SHALL go to TO_HIGH with cnt:=0; with sync=0 it SHALL stay in LOW.
REQ-013 In TO_HIGH with sync=0, the FSM SHALL return to LOW with cnt:=0 and SHALL emit no pulse (bounce rejected).
REQ-014 In TO_HIGH with sync=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to HIGH, set btn_o:=1 and assert rise_o for exactly the following cycle.
REQ-015 In TO_HIGH with sync=1 and cnt<DEBOUNCE_CYCLES-1, the FSM SHALL increment cnt.
REQ-016 HIGH and TO_LOW SHALL mirror REQ-012..015 with levels inverted; acceptance SHALL set btn_o:=0 and pulse fall_o.
REQ-017 Latency: if btn_i changes before clock edge 0 and is held, btn_o SHALL change and the pulse SHALL assert at edge SYNC_STAGES+DEBOUNCE_CYCLES, with no earlier and no later change.
REQ-018 Any input excursion shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave btn_o, rise_o and fall_o unchanged.
REQ-019 The counter SHALL never wrap: it is cleared on every entry to TO_HIGH or TO_LOW and is only compared while in those states.
REQ-020 rise_o and fall_o SHALL never be asserted simultaneously on one channel, and each accepted change SHALL produce exactly one pulse.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce a pulse in the same cycle.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from btn_i to any output.

Reset
REQ-023 On arstn_i=0, the block SHALL asynchronously clear all synchronizer flops, all FSMs (to LOW), all counters, btn_o, rise_o and fall_o.
REQ-024 Assertion of reset mid-count SHALL abandon the pending change; after release, a held-high input SHALL be re-qualified per REQ-017 and counted from the first edge after release.
REQ-025 Reset release SHALL be synchronous to clk_i in the parent; while held, the block SHALL emit no pulse.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=4)
REQ-026 Clean press: btn_i[0] 0->1 before edge 0 and held -> btn_o[0]=1 and rise_o[0]=1 after edge 6 only; rise_o[0]=0 after edge 7.
REQ-027 Bounce: btn_i[1] high for 3 cycles, low for 1 cycle, then high and held -> no pulse during the 3-cycle excursion; btn_o[1] rises 6 edges after the final rising change.
REQ-028 Release: channel 0 in HIGH, btn_i[0] 1->0 before edge 0 and held -> btn_o[0]=0 and fall_o[0]=1 after edge 6 only.
REQ-029 Simultaneous events: btn_i=4'b1111 applied at once -> rise_o=4'b1111 in a single cycle, then 4'b0000.
REQ-030 Reset mid-operation: arstn_i pulsed low at edge 4 of a press -> all outputs 0 immediately; with btn_i still high, rise_o asserts 6 edges after the first edge following release.
